// File: rtl/lvds_frame_rx.sv
// lvds_frame_rx: word-framing receiver for a 4-lane LVDS bus.
// Assembles one nibble per clk into 16-bit words, hunts for SYNC_WORD, then
// frames FRAME_WORDS payload words between sync slots and tracks sync health.
// Ports:
//   clk       forwarded LVDS clock, rising-edge sampling
//   rst       synchronous active-high reset
//   lvds_in   lane samples, one nibble per clk
//   out_data  payload word, first nibble in [15:12]
//   out_valid one-cycle strobe for out_data
//   out_sof   first payload word after a sync slot
//   locked    framing locked (status LED)
//   sync_err  one-cycle pulse per missed sync
//   err_cnt   saturating missed-sync count, cleared only by rst
module lvds_frame_rx #(
    parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
    parameter int unsigned FRAME_WORDS = 64,
    parameter int unsigned MISS_LIMIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  lvds_in,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned POS_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [11:0]      sr;
    logic [1:0]       nib_cnt, nib_cnt_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic [3:0]       miss_cnt, miss_cnt_nxt;
    logic             first_word, first_word_nxt;
    logic [15:0]      out_data_nxt;
    logic             out_valid_nxt, out_sof_nxt, sync_err_nxt, locked_nxt;
    logic [7:0]       err_cnt_nxt;

    // Shared decode: candidate word spans the current nibble and the previous three
    logic [15:0] cand_c;
    logic        sync_hit_c, word_done_c, sync_slot_c, drop_c;
    logic [3:0]  miss_inc_c;

    assign cand_c      = {sr, lvds_in};
    assign sync_hit_c  = (cand_c == SYNC_WORD);
    assign word_done_c = (state == LOCKED) && (nib_cnt == 2'd3);
    assign sync_slot_c = (pos == POS_W'(FRAME_WORDS));
    assign miss_inc_c  = miss_cnt + 4'd1;
    assign drop_c      = word_done_c && sync_slot_c && !sync_hit_c
                         && (miss_inc_c == 4'(MISS_LIMIT));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            sr         <= 12'd0;
            nib_cnt    <= 2'd0;
            pos        <= '0;
            miss_cnt   <= 4'd0;
            first_word <= 1'b0;
            out_data   <= 16'd0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            state      <= state_nxt;
            sr         <= {sr[7:0], lvds_in};
            nib_cnt    <= nib_cnt_nxt;
            pos        <= pos_nxt;
            miss_cnt   <= miss_cnt_nxt;
            first_word <= first_word_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            out_sof    <= out_sof_nxt;
            locked     <= locked_nxt;
            sync_err   <= sync_err_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (sync_hit_c) state_nxt = LOCKED;
            LOCKED:  if (drop_c)     state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    // Output and counter next values
    always_comb begin
        nib_cnt_nxt    = nib_cnt;
        pos_nxt        = pos;
        miss_cnt_nxt   = miss_cnt;
        first_word_nxt = first_word;
        out_data_nxt   = out_data;
        out_valid_nxt  = 1'b0;
        out_sof_nxt    = 1'b0;
        sync_err_nxt   = 1'b0;
        err_cnt_nxt    = err_cnt;
        locked_nxt     = (state_nxt == LOCKED);

        case (state)
            HUNT: begin
                if (sync_hit_c) begin
                    nib_cnt_nxt    = 2'd0;
                    pos_nxt        = '0;
                    miss_cnt_nxt   = 4'd0;
                    first_word_nxt = 1'b1;
                end
            end
            LOCKED: begin
                nib_cnt_nxt = nib_cnt + 2'd1;
                if (word_done_c) begin
                    pos_nxt = sync_slot_c ? '0 : pos + POS_W'(1);
                    if (!sync_slot_c) begin
                        // Payload slot: positional only, a sync-valued word is data
                        out_data_nxt   = cand_c;
                        out_valid_nxt  = 1'b1;
                        out_sof_nxt    = first_word;
                        first_word_nxt = 1'b0;
                    end else if (sync_hit_c) begin
                        miss_cnt_nxt   = 4'd0;
                        first_word_nxt = 1'b1;
                    end else begin
                        // Missed sync: keep framing unless the miss limit is hit
                        sync_err_nxt   = 1'b1;
                        if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
                        miss_cnt_nxt   = drop_c ? 4'd0 : miss_inc_c;
                        first_word_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lvds_frame_rx.sv
// Directed bench for lvds_frame_rx with FRAME_WORDS = 4, MISS_LIMIT = 2.
module tb_lvds_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  lvds_in;
    logic [15:0] out_data;
    logic        out_valid, out_sof, locked, sync_err;
    logic [7:0]  err_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        proto_bad = 1'b0;
    logic        prev_valid = 1'b0;

    lvds_frame_rx #(
        .SYNC_WORD  (16'hA5C3),
        .FRAME_WORDS(4),
        .MISS_LIMIT (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lvds_in  (lvds_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_sof  (out_sof),
        .locked   (locked),
        .sync_err (sync_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Protocol watch: sof only with valid, never two valid strobes in a row
    always @(posedge clk) begin
        #1;
        if (out_sof && !out_valid) proto_bad = 1'b1;
        if (out_valid && prev_valid) proto_bad = 1'b1;
        prev_valid = out_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        lvds_in = n;
        tick();
    endtask

    // Send four nibbles MSB first; flag any valid strobe before the last nibble lands
    task automatic send_raw(input logic [15:0] w);
        logic [15:0] v;
        v = w;
        for (int i = 3; i >= 0; i--) begin
            send_nib(v[i*4 +: 4]);
            if (i != 0 && out_valid) proto_bad = 1'b1;
        end
    endtask

    task automatic send_word(input string tag, input logic [15:0] w, input logic sof);
        send_raw(w);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(w));
        check({tag, ".sof"}, 32'(out_sof), 32'(sof));
    endtask

    task automatic send_frame_quiet(input logic [15:0] sync_w);
        for (int k = 0; k < 4; k++) send_raw(16'h1234 + 16'(k));
        send_raw(sync_w);
    endtask

    logic spurious;

    initial begin
        rst = 1'b1;
        lvds_in = 4'h0;
        tick();
        tick();
        check("rst.locked", 32'(locked), 32'd0);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        check("rst.err_cnt", 32'(err_cnt), 32'd0);
        check("rst.sync_err", 32'(sync_err), 32'd0);
        rst = 1'b0;

        // Lock after noise
        spurious = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            send_nib(4'(i % 10));
            if (locked || out_valid) spurious = 1'b1;
        end
        check("noise.quiet", 32'(spurious), 32'd0);
        send_nib(4'hA);
        send_nib(4'h5);
        send_nib(4'hC);
        check("lock.before", 32'(locked), 32'd0);
        send_nib(4'h3);
        check("lock.after", 32'(locked), 32'd1);
        check("lock.novalid", 32'(out_valid), 32'd0);

        // Frame content
        send_word("f1w0", 16'h1234, 1'b1);
        send_word("f1w1", 16'h5678, 1'b0);
        send_word("f1w2", 16'h9ABC, 1'b0);
        send_word("f1w3", 16'hDEF0, 1'b0);
        send_raw(16'hA5C3);
        check("f1.sync_err", 32'(sync_err), 32'd0);
        check("f1.sync_novalid", 32'(out_valid), 32'd0);
        send_word("f2w0", 16'h1111, 1'b1);
        send_word("f2w1", 16'h2222, 1'b0);
        send_word("f2w2", 16'h3333, 1'b0);
        send_word("f2w3", 16'h4444, 1'b0);

        // Single miss
        send_raw(16'h0000);
        check("miss1.sync_err", 32'(sync_err), 32'd1);
        check("miss1.err_cnt", 32'(err_cnt), 32'd1);
        check("miss1.locked", 32'(locked), 32'd1);
        send_word("f3w0", 16'h5555, 1'b1);
        check("miss1.pulse", 32'(sync_err), 32'd0);
        send_word("f3w1", 16'h6666, 1'b0);
        send_word("f3w2", 16'h7777, 1'b0);
        send_word("f3w3", 16'h8888, 1'b0);
        send_raw(16'hA5C3);
        check("good.sync_err", 32'(sync_err), 32'd0);
        check("good.err_cnt", 32'(err_cnt), 32'd1);

        // Payload equal to sync word
        send_word("f4w0", 16'h0001, 1'b1);
        send_word("f4w1", 16'hA5C3, 1'b0);
        send_word("f4w2", 16'h0003, 1'b0);
        send_word("f4w3", 16'h0004, 1'b0);
        send_raw(16'hA5C3);
        check("f4.sync_err", 32'(sync_err), 32'd0);
        send_word("f5w0", 16'hBEEF, 1'b1);
        send_word("f5w1", 16'h0102, 1'b0);
        send_word("f5w2", 16'h0304, 1'b0);
        send_word("f5w3", 16'h0506, 1'b0);

        // Loss of lock: two consecutive misses (miss counter cleared by last good sync)
        send_raw(16'h0000);
        check("lol1.sync_err", 32'(sync_err), 32'd1);
        check("lol1.err_cnt", 32'(err_cnt), 32'd2);
        check("lol1.locked", 32'(locked), 32'd1);
        send_word("f6w0", 16'hCAFE, 1'b1);
        send_word("f6w1", 16'h0011, 1'b0);
        send_word("f6w2", 16'h0022, 1'b0);
        send_word("f6w3", 16'h0033, 1'b0);
        send_raw(16'h0000);
        check("lol2.sync_err", 32'(sync_err), 32'd1);
        check("lol2.err_cnt", 32'(err_cnt), 32'd3);
        check("lol2.locked", 32'(locked), 32'd0);
        spurious = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send_nib(4'(i));
            if (locked || out_valid) spurious = 1'b1;
        end
        check("hunt.quiet", 32'(spurious), 32'd0);
        send_raw(16'hA5C3);
        check("relock.locked", 32'(locked), 32'd1);
        check("relock.err_cnt", 32'(err_cnt), 32'd3);
        send_word("f7w0", 16'h7E57, 1'b1);

        // Reset mid-frame at pos 2 with a partial sync in flight
        send_word("f7w1", 16'h0F0F, 1'b0);
        send_nib(4'hA);
        send_nib(4'h5);
        rst = 1'b1;
        lvds_in = 4'hC;
        tick();
        rst = 1'b0;
        check("mrst.locked", 32'(locked), 32'd0);
        check("mrst.valid", 32'(out_valid), 32'd0);
        check("mrst.sof", 32'(out_sof), 32'd0);
        check("mrst.data", 32'(out_data), 32'd0);
        check("mrst.sync_err", 32'(sync_err), 32'd0);
        check("mrst.err_cnt", 32'(err_cnt), 32'd0);
        send_nib(4'h3);
        check("mrst.stale", 32'(locked), 32'd0);
        send_raw(16'hA5C3);
        check("mrst.relock", 32'(locked), 32'd1);
        send_word("f8w0", 16'h1357, 1'b1);
        send_word("f8w1", 16'h2468, 1'b0);
        send_word("f8w2", 16'h369C, 1'b0);
        send_word("f8w3", 16'h48C0, 1'b0);
        send_raw(16'hA5C3);
        check("f8.sync_err", 32'(sync_err), 32'd0);

        // err_cnt saturation: 150 lock / drop rounds = 300 misses
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 150; r++) begin
            send_raw(16'hA5C3);
            send_frame_quiet(16'h0000);
            send_frame_quiet(16'h0000);
            if (r == 126) check("sat.254", 32'(err_cnt), 32'd254);
            if (r == 127) check("sat.255", 32'(err_cnt), 32'd255);
        end
        check("sat.final", 32'(err_cnt), 32'd255);
        check("sat.locked", 32'(locked), 32'd0);

        check("protocol", 32'(proto_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
